// File: rtl/mdu_issue.sv
// Issue stage for the iterative HI/LO multiply/divide ALU: latches operands, stalls EX,
// serialises MTHI/MTLO writes, returns MFHI/MFLO. Optional feature macro: MDU_DIV0_BYPASS_EN.
`ifndef W_FUNC
`define W_FUNC 2
`endif
`ifndef FUNC_IDLE
`define FUNC_IDLE 2'd0
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 2'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 2'd2
`endif

module mdu_issue #(
  parameter int TIMEOUT = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  input  logic [31:0]         req_a,
  input  logic [31:0]         req_b,
  input  logic                pipe_flush,
  input  logic                pipe_stall,
  output logic                ex_stall,
  output logic [31:0]         rd_data,
  output logic                timeout_err,
  output logic [`W_FUNC-1:0]  alu_func,
  output logic                alu_sign,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic                alu_flush,
  output logic                alu_hold,
  input  logic                alu_busy,
  input  logic [31:0]         hi_in,
  input  logic [31:0]         lo_in,
  output logic                hi_we,
  output logic                lo_we,
  output logic [31:0]         hi_wd,
  output logic [31:0]         lo_wd
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [`W_FUNC-1:0] F_IDLE = `FUNC_IDLE;
  localparam logic [`W_FUNC-1:0] F_MUL  = `FUNC_MUL;
  localparam logic [`W_FUNC-1:0] F_DIV  = `FUNC_DIV;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, WLO} state_t;

  state_t              state_q, state_d;
  logic [`W_FUNC-1:0]  func_q, func_d;
  logic                sign_q, sign_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [CW-1:0]       tmo_q, tmo_d;
  logic                first_q, first_d;
  logic                byp_done_q, byp_done_d;
  logic                accept, div0, start, alu_done, tmo_hit, mt_ok;

  // byp_done keeps the already-serviced divide-by-zero from re-issuing while EX still holds it
  assign accept = (state_q == IDLE) && req_valid && !pipe_flush && !req_op[2] && !byp_done_q;
`ifdef MDU_DIV0_BYPASS_EN
  assign div0       = accept && req_op[1] && (req_b == 32'd0);
  assign byp_done_d = ((state_q == WLO) && !pipe_flush) || (byp_done_q && pipe_stall && !pipe_flush);
`else
  assign div0       = 1'b0;
  assign byp_done_d = 1'b0;
`endif
  assign start    = accept && !div0;
  // alu_busy is registered in the ALU, so it is meaningless in the first BUSY cycle
  assign alu_done = (state_q == BUSY) && !first_q && !alu_busy;
  assign tmo_hit  = (TIMEOUT != 0) && (state_q == BUSY) && !alu_done && (tmo_q == CW'(TIMEOUT - 1));
  assign mt_ok    = (state_q == IDLE) && req_valid && !pipe_stall && !pipe_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      func_q     <= F_IDLE;
      sign_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tmo_q      <= '0;
      first_q    <= 1'b0;
      byp_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      sign_q     <= sign_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tmo_q      <= tmo_d;
      first_q    <= first_d;
      byp_done_q <= byp_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    sign_d  = sign_q;
    a_d     = a_q;
    b_d     = b_q;
    tmo_d   = '0;
    first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (div0) begin
          state_d = WLO;
        end else if (start) begin
          state_d = BUSY;
          func_d  = req_op[1] ? F_DIV : F_MUL;
          sign_d  = ~req_op[0];
          a_d     = req_a;
          b_d     = req_b;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        tmo_d = tmo_q + CW'(1);
        if (alu_done) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = IDLE;
          func_d  = F_IDLE;
        end
      end
      DONE: begin
        if (!pipe_stall) begin
          state_d = IDLE;
          func_d  = F_IDLE;
        end
      end
      WLO:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pipe_flush) begin
      state_d = IDLE;
      func_d  = F_IDLE;
      tmo_d   = '0;
      first_d = 1'b0;
    end
  end

  always_comb begin
    ex_stall    = accept || (state_q == BUSY) || (state_q == WLO);
    hi_we       = !pipe_flush && (div0 || (mt_ok && (req_op == 3'd4)));
    lo_we       = !pipe_flush && ((state_q == WLO) || (mt_ok && (req_op == 3'd5)));
    hi_wd       = req_a;
    lo_wd       = (state_q == WLO) ? 32'hFFFF_FFFF : req_a;
    alu_flush   = pipe_flush || tmo_hit;
    timeout_err = tmo_hit && !pipe_flush;
    alu_hold    = (state_q == DONE) && pipe_stall;
    case (req_op)
      3'd6:    rd_data = hi_in;
      3'd7:    rd_data = lo_in;
      default: rd_data = 32'd0;
    endcase
  end

  assign alu_func = func_q;
  assign alu_sign = sign_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
endmodule
